// File: rtl/decoder_n_to_2n_seq.sv
// Registered N-to-2^N one-hot decoder with enable, direct load and hold.
// Defining DECODER_SCAN_EN adds an auto-scan mode with a programmable dwell time.
module decoder_n_to_2n_seq #(
  parameter int N       = 2,
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                E,
  input  logic                mode,
  input  logic                load,
  input  logic [N-1:0]        A,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [2**N-1:0]     Y,
  output logic                y_valid,
  output logic [N-1:0]        pos,
  output logic                wrap
);

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

  state_t            state_reg, state_next;
  logic [N-1:0]      pos_next;
  logic [2**N-1:0]   y_next;

`ifdef DECODER_SCAN_EN
  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic               wrap_next;

  always_comb begin
    state_next = state_reg;
    pos_next   = pos;
    cnt_next   = cnt_reg;
    wrap_next  = 1'b0;
    if (!E) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE, HOLD: begin
          if (mode) begin
            state_next = SCAN;
            pos_next   = '0;
            cnt_next   = '0;
          end else if (load) begin
            state_next = HOLD;
            pos_next   = A;
          end
        end
        SCAN: begin
          // >= rather than == so a dwell lowered mid-count advances at once
          if (!mode) begin
            state_next = HOLD;
            cnt_next   = '0;
          end else if (cnt_reg >= dwell) begin
            pos_next  = pos + 1'b1;
            cnt_next  = '0;
            wrap_next = (pos == {N{1'b1}});
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end
`else
  logic unused_scan_inputs;
  assign unused_scan_inputs = ^{mode, dwell};
  assign wrap = 1'b0;

  always_comb begin
    state_next = state_reg;
    pos_next   = pos;
    if (!E) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, HOLD: begin
          if (load) begin
            state_next = HOLD;
            pos_next   = A;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end
`endif

  generate
    for (genvar gi = 0; gi < 2**N; gi++) begin : g_onehot
      assign y_next[gi] = (state_next != IDLE) && (pos_next == N'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pos       <= '0;
      Y         <= '0;
      y_valid   <= 1'b0;
`ifdef DECODER_SCAN_EN
      cnt_reg   <= '0;
      wrap      <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      pos       <= pos_next;
      Y         <= y_next;
      y_valid   <= (state_next != IDLE);
`ifdef DECODER_SCAN_EN
      cnt_reg   <= cnt_next;
      wrap      <= wrap_next;
`endif
    end
  end

endmodule

// File: tb/tb_decoder_n_to_2n_seq.sv
// Directed bench for decoder_n_to_2n_seq: an N=2 and an N=3 instance share
// the control inputs; scan checks run only when DECODER_SCAN_EN is defined.
module tb_decoder_n_to_2n_seq;

  logic       clk = 1'b0;
  logic       rst_n, e, mode, load;
  logic [1:0] a2;
  logic [2:0] a3;
  logic [7:0] dwell;
  logic [3:0] y2;
  logic [7:0] y3;
  logic       v2, v3, w2, w3;
  logic [1:0] p2;
  logic [2:0] p3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_n_to_2n_seq #(.N(2), .DWELL_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .E(e), .mode(mode), .load(load), .A(a2),
    .dwell(dwell), .Y(y2), .y_valid(v2), .pos(p2), .wrap(w2)
  );

  decoder_n_to_2n_seq #(.N(3), .DWELL_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .E(e), .mode(mode), .load(load), .A(a3),
    .dwell(dwell), .Y(y3), .y_valid(v3), .pos(p3), .wrap(w3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] seq3 [9];
    seq3 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};

    rst_n = 1'b0; e = 1'b0; mode = 1'b0; load = 1'b0;
    a2 = '0; a3 = '0; dwell = '0;
    #12;
    check("rst_y", y2, 4'b0000);
    check("rst_valid", v2, 1'b0);
    check("rst_pos", p2, 2'd0);
    check("rst_wrap", w2, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // direct load and hold
    step();
    e = 1'b1; load = 1'b1; a2 = 2'b10; a3 = 3'd5;
    step();
    check("load2_y", y2, 4'b0100);
    check("load2_valid", v2, 1'b1);
    check("load2_pos", p2, 2'd2);
    check("n3_load5_y", y3, 8'b0010_0000);
    check("n3_load5_pos", p3, 3'd5);
    load = 1'b0; a2 = 2'b01;
    step();
    check("hold_y", y2, 4'b0100);
    step();
    check("hold_y2", y2, 4'b0100);

    load = 1'b1; a2 = 2'b11;
    step();
    check("load3_y", y2, 4'b1000);
    load = 1'b0; e = 1'b0;
    step();
    check("dis_y", y2, 4'b0000);
    check("dis_valid", v2, 1'b0);
    check("dis_pos", p2, 2'd3);

    // disable beats load
    load = 1'b1; a2 = 2'b00;
    step();
    check("dis_prio_y", y2, 4'b0000);
    check("dis_prio_valid", v2, 1'b0);
    load = 1'b0;

`ifdef DECODER_SCAN_EN
    // N=2 scan, dwell=1: each position held two cycles, wrap on return to 0
    dwell = 8'd1; mode = 1'b1; load = 1'b1; a2 = 2'b01; e = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      load = 1'b0;
      check($sformatf("scan_d1_y[%0d]", i), y2, seq3[i]);
      check($sformatf("scan_d1_wrap[%0d]", i), w2, (i == 8));
    end
    e = 1'b0;
    step();
    check("scan_dis_wrap", w2, 1'b0);

    // N=3 scan, dwell=0: advance every cycle, wrap every 8
    dwell = 8'd0; e = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      check($sformatf("n3_pos[%0d]", k), p3, k % 8);
      check($sformatf("n3_wrap[%0d]", k), w3, (k > 0 && k % 8 == 0));
    end
    check("n3_y_pos0", y3, 8'b0000_0001);
    dwell = 8'd5;
    step();
    step();
    check("n3_dwell5_pos", p3, 3'd0);
    dwell = 8'd0;
    step();
    check("n3_dwell_cut_pos", p3, 3'd1);

    // scan to pos 2 then freeze; load ignored in that cycle
    e = 1'b0;
    step();
    e = 1'b1;
    step();
    step();
    step();
    check("pre_freeze_pos", p2, 2'd2);
    mode = 1'b0; load = 1'b1; a2 = 2'b00;
    step();
    check("freeze_y", y2, 4'b0100);
    check("freeze_pos", p2, 2'd2);
    load = 1'b0;
    step();
    check("freeze_hold_y", y2, 4'b0100);
`else
    // without scan support mode=1 acts as a plain load and never rotates
    e = 1'b1; mode = 1'b1; load = 1'b1; a2 = 2'b01; dwell = 8'd0;
    step();
    check("noscan_y", y2, 4'b0010);
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("noscan_y[%0d]", i), y2, 4'b0010);
      check($sformatf("noscan_wrap[%0d]", i), w2, 1'b0);
    end
`endif

    // asynchronous reset lands before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_y", y2, 4'b0000);
    check("async_pos", p2, 2'd0);
    check("async_wrap", w2, 1'b0);
    check("async_valid", v2, 1'b0);
    check("async_n3_y", y3, 8'b0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
